// File: rtl/mfm_sector_reader.sv
// MFM sector read sequencer: hunts the ID mark for a requested C/H/R, then streams
// that sector's data field out and reports CRC / lookup status to the host logic.
module mfm_sector_reader #(
  parameter int unsigned MAX_IDS = 32,
  parameter int unsigned GAP_MAX = 43
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Abort,
  input  logic [7:0] i_Track,
  input  logic       i_Head,
  input  logic [7:0] i_Sector,
  input  logic [7:0] i_Byte,
  input  logic       i_Byte_Valid,
  input  logic       i_Mark,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  output logic [1:0] o_Size_N,
  output logic       o_Deleted,
  output logic       o_Busy,
  output logic       o_Done,
  output logic [2:0] o_Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT_ID, S_ID_FLD, S_ID_CHK, S_HUNT_DAM, S_DATA, S_DCRC, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    E_OK = 3'd0, E_ID_CRC = 3'd1, E_NOT_FOUND = 3'd2,
    E_NO_DAM = 3'd3, E_DATA_CRC = 3'd4, E_ABORT = 3'd5
  } err_e;

  localparam logic [7:0] ID_LIM  = 8'(MAX_IDS);
  localparam logic [7:0] GAP_LIM = 8'(GAP_MAX);

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] r;
    r = crc ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic [1:0]  mark_cnt_q, mark_cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  trk_q, trk_d, sec_q, sec_d;
  logic        head_q, head_d;
  logic [7:0]  id_cnt_q, id_cnt_d, gap_q, gap_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  id_c_q, id_c_d, id_h_q, id_h_d, id_r_q, id_r_d, id_n_q, id_n_d;
  logic [1:0]  size_q, size_d;
  logic        deleted_q, deleted_d, done_q, done_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;

  logic        busy, in_data, mark_ev, byte_ev, am_byte, id_match;
  logic [7:0]  ev_byte, id_cnt_inc, gap_inc;
  logic [10:0] data_last;

  // Inside the data field an A1 mark is just payload, so it must not disturb the mark run or CRC.
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign in_data    = (state_q == S_DATA) || (state_q == S_DCRC);
  assign mark_ev    = i_Mark && !in_data;
  assign byte_ev    = i_Byte_Valid || (i_Mark && in_data);
  assign ev_byte    = i_Mark ? 8'hA1 : i_Byte;
  assign am_byte    = i_Byte_Valid && (mark_cnt_q == 2'd3);
  assign id_match   = (id_c_q == trk_q) && (id_h_q == {7'b0, head_q}) && (id_r_q == sec_q);
  assign id_cnt_inc = (id_cnt_q == 8'hFF) ? id_cnt_q : id_cnt_q + 8'd1;
  assign gap_inc    = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
  assign data_last  = (11'd128 << size_q) - 11'd1;

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    mark_cnt_d   = mark_cnt_q;
    crc_d        = crc_q;
    trk_d        = trk_q;
    head_d       = head_q;
    sec_d        = sec_q;
    id_cnt_d     = id_cnt_q;
    gap_d        = gap_q;
    byte_cnt_d   = byte_cnt_q;
    id_c_d       = id_c_q;
    id_h_d       = id_h_q;
    id_r_d       = id_r_q;
    id_n_d       = id_n_q;
    size_d       = size_q;
    deleted_d    = deleted_q;
    done_d       = 1'b0;
    data_d       = data_q;
    data_valid_d = 1'b0;

    if (mark_ev) begin
      mark_cnt_d = (mark_cnt_q == 2'd3) ? 2'd3 : mark_cnt_q + 2'd1;
      crc_d      = crc_step((mark_cnt_q == 2'd0) ? 16'hFFFF : crc_q, 8'hA1);
    end else if (byte_ev) begin
      mark_cnt_d = 2'd0;
      crc_d      = crc_step(crc_q, ev_byte);
    end

    case (state_q)
      S_IDLE: begin
        if (i_Start && !i_Abort) begin
          state_d   = S_HUNT_ID;
          trk_d     = i_Track;
          head_d    = i_Head;
          sec_d     = i_Sector;
          id_cnt_d  = '0;
          err_d     = E_OK;
          deleted_d = 1'b0;
          size_d    = '0;
        end
      end
      S_HUNT_ID: begin
        if (am_byte && (i_Byte == 8'hFE)) begin
          state_d    = S_ID_FLD;
          byte_cnt_d = '0;
        end
      end
      S_ID_FLD: begin
        if (byte_ev) begin
          case (byte_cnt_q[2:0])
            3'd0:    id_c_d = ev_byte;
            3'd1:    id_h_d = ev_byte;
            3'd2:    id_r_d = ev_byte;
            3'd3:    id_n_d = ev_byte;
            default: ;
          endcase
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (byte_cnt_q == 11'd5) state_d = S_ID_CHK;
        end
      end
      S_ID_CHK: begin
        id_cnt_d = id_cnt_inc;
        if (id_match && (crc_q != 16'h0000)) begin
          state_d = S_DONE;
          err_d   = E_ID_CRC;
          done_d  = 1'b1;
        end else if (id_match) begin
          state_d = S_HUNT_DAM;
          gap_d   = '0;
          size_d  = (id_n_q > 8'd3) ? 2'd3 : id_n_q[1:0];
        end else if (id_cnt_inc == ID_LIM) begin
          state_d = S_DONE;
          err_d   = E_NOT_FOUND;
          done_d  = 1'b1;
        end else begin
          state_d = S_HUNT_ID;
        end
      end
      S_HUNT_DAM: begin
        if (am_byte) begin
          if ((i_Byte == 8'hFB) || (i_Byte == 8'hF8)) begin
            state_d    = S_DATA;
            deleted_d  = (i_Byte == 8'hF8);
            byte_cnt_d = '0;
          end else begin
            state_d = S_DONE;
            err_d   = E_NO_DAM;
            done_d  = 1'b1;
          end
        end else if (i_Byte_Valid) begin
          gap_d = gap_inc;
          if (gap_inc >= GAP_LIM) begin
            state_d = S_DONE;
            err_d   = E_NO_DAM;
            done_d  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (byte_ev) begin
          data_d       = ev_byte;
          data_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + 11'd1;
          if (byte_cnt_q == data_last) begin
            state_d    = S_DCRC;
            byte_cnt_d = '0;
          end
        end
      end
      S_DCRC: begin
        if (byte_ev) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (byte_cnt_q == 11'd1) begin
            state_d = S_DONE;
            err_d   = (crc_d != 16'h0000) ? E_DATA_CRC : E_OK;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any byte event handled above in the same cycle.
    if (i_Abort && busy) begin
      state_d      = S_IDLE;
      err_d        = E_ABORT;
      done_d       = 1'b1;
      data_valid_d = 1'b0;
      data_d       = data_q;
      deleted_d    = deleted_q;
      size_d       = size_q;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      err_q        <= E_OK;
      mark_cnt_q   <= '0;
      crc_q        <= '0;
      trk_q        <= '0;
      head_q       <= 1'b0;
      sec_q        <= '0;
      id_cnt_q     <= '0;
      gap_q        <= '0;
      byte_cnt_q   <= '0;
      id_c_q       <= '0;
      id_h_q       <= '0;
      id_r_q       <= '0;
      id_n_q       <= '0;
      size_q       <= '0;
      deleted_q    <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      mark_cnt_q   <= mark_cnt_d;
      crc_q        <= crc_d;
      trk_q        <= trk_d;
      head_q       <= head_d;
      sec_q        <= sec_d;
      id_cnt_q     <= id_cnt_d;
      gap_q        <= gap_d;
      byte_cnt_q   <= byte_cnt_d;
      id_c_q       <= id_c_d;
      id_h_q       <= id_h_d;
      id_r_q       <= id_r_d;
      id_n_q       <= id_n_d;
      size_q       <= size_d;
      deleted_q    <= deleted_d;
      done_q       <= done_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign o_Data       = data_q;
  assign o_Data_Valid = data_valid_q;
  assign o_Size_N     = size_q;
  assign o_Deleted    = deleted_q;
  assign o_Busy       = busy;
  assign o_Done       = done_q;
  assign o_Err        = err_q;

endmodule
